vcache_req_driver: RTL and testbench

//  Request-side master for one vcache: the initiator end of the cache packet handshake that

---
 rtl/vcache_req_driver_pkg.sv | 35 +++
 rtl/vcache_req_driver_if.sv | 34 +++
 rtl/vcache_req_driver_fifo.sv | 61 ++++++
 rtl/vcache_req_driver.sv | 155 +++++++++++++++
 tb/tb_vcache_req_driver.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vcache_req_driver_pkg.sv
// rtl/vcache_req_driver_pkg.sv - shared enums, cache opcodes and packet sizing for the vcache request driver
package vcache_req_driver_pkg;

    typedef enum logic [1:0] {
        TRACE_LD   = 2'd0,
        TRACE_ST   = 2'd1,
        TRACE_DONE = 2'd2,
        TRACE_NOP  = 2'd3
    } trace_op_e;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FIN   = 2'd2
    } state_e;

    // bsg_cache opcode encodings for the word-sized accesses we issue
    localparam logic [5:0] CACHE_OP_LW = 6'b000010;
    localparam logic [5:0] CACHE_OP_LD = 6'b000011;
    localparam logic [5:0] CACHE_OP_SW = 6'b001010;
    localparam logic [5:0] CACHE_OP_SD = 6'b001011;

    // packet layout is {opcode[5:0], addr, data, byte mask}
    function automatic int bsg_cache_pkt_width(input int addr_width, input int data_width);
        return 6 + addr_width + data_width + data_width / 8;
    endfunction

    function automatic logic [5:0] mem_opcode(input logic is_store, input int data_width);
        if (data_width == 64) begin
            return is_store ? CACHE_OP_SD : CACHE_OP_LD;
        end
        return is_store ? CACHE_OP_SW : CACHE_OP_LW;
    endfunction

endpackage

// File: rtl/vcache_req_driver_if.sv
// rtl/vcache_req_driver_if.sv - trace input, cache request and cache response handshakes of the driver
interface vcache_req_driver_if
    import vcache_req_driver_pkg::*;
#(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
);
    localparam int pkt_width_lp = bsg_cache_pkt_width(addr_width_p, data_width_p);

    logic                    trace_v_i;
    logic [1:0]              trace_op_i;
    logic [addr_width_p-1:0] trace_addr_i;
    logic [data_width_p-1:0] trace_data_i;
    logic                    trace_yumi_o;

    logic [pkt_width_lp-1:0] cache_pkt_o;
    logic                    v_o;
    logic                    ready_i;

    logic [data_width_p-1:0] data_i;
    logic                    v_i;
    logic                    yumi_o;

    modport master (
        input  trace_v_i, trace_op_i, trace_addr_i, trace_data_i, ready_i, data_i, v_i,
        output trace_yumi_o, cache_pkt_o, v_o, yumi_o
    );

    modport slave (
        output trace_v_i, trace_op_i, trace_addr_i, trace_data_i, ready_i, data_i, v_i,
        input  trace_yumi_o, cache_pkt_o, v_o, yumi_o
    );

endinterface

// File: rtl/vcache_req_driver_fifo.sv
// rtl/vcache_req_driver_fifo.sv - small 1r1w circular FIFO holding {is_ld, expected data} per outstanding request
module vcache_req_driver_fifo #(
    parameter int els_p   = 4,
    parameter int width_p = 33
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [width_p-1:0] push_data,
    output logic               ready,
    output logic               valid,
    output logic [width_p-1:0] pop_data,
    input  logic               pop
);
    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [cnt_w-1:0]   count;
    logic               do_push;
    logic               do_pop;

    function automatic logic [ptr_w-1:0] bump(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    assign ready    = (count != cnt_w'(els_p));
    assign valid    = (count != '0);
    assign pop_data = mem[rd_ptr];
    assign do_push  = push & ready;
    assign do_pop   = pop & valid;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vcache_req_driver.sv
// rtl/vcache_req_driver.sv - trace-driven vcache request master with in-order load checking and end-of-trace stat strobe
module vcache_req_driver
    import vcache_req_driver_pkg::*;
#(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int max_out_p    = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    vcache_req_driver_if.master     bus,
    output logic [31:0]             ld_count_o,
    output logic [31:0]             st_count_o,
    output logic [31:0]             mismatch_count_o,
    output logic                    print_stat_v_o,
    output logic [data_width_p-1:0] print_stat_tag_o,
    output logic                    done_o,
    output logic                    error_o
);
    localparam int out_w  = $clog2(max_out_p + 1);
    localparam int mask_w = data_width_p / 8;

    state_e                  state_r, state_n;
    trace_op_e               op;
    logic [out_w-1:0]        outstanding_r;
    logic [data_width_p-1:0] tag_r;
    logic [31:0]             ld_count_r, st_count_r, mismatch_count_r;
    logic                    error_r;

    logic                    is_mem, can_issue, issue, retire;
    logic                    req_v, trace_yumi, print_stat_v, done_consume;
    logic                    fifo_ready, fifo_v;
    logic [data_width_p:0]   fifo_data;

    assign op     = trace_op_e'(bus.trace_op_i);
    assign is_mem = (op == TRACE_LD) || (op == TRACE_ST);

    // FIFO ready is redundant with the outstanding limit but keeps the queue safe on its own
    assign can_issue = (outstanding_r < out_w'(max_out_p)) & fifo_ready;
    assign issue     = req_v & bus.ready_i;
    assign retire    = bus.v_i & fifo_v;

    assign bus.cache_pkt_o  = {mem_opcode(op == TRACE_ST, data_width_p),
                               bus.trace_addr_i, bus.trace_data_i, {mask_w{1'b1}}};
    assign bus.v_o          = req_v;
    assign bus.trace_yumi_o = trace_yumi;
    assign bus.yumi_o       = bus.v_i;

    vcache_req_driver_fifo #(
        .els_p  (max_out_p),
        .width_p(1 + data_width_p)
    ) exp_fifo (
        .clk      (clk_i),
        .reset    (reset_i),
        .push     (issue),
        .push_data({op == TRACE_LD, bus.trace_data_i}),
        .ready    (fifo_ready),
        .valid    (fifo_v),
        .pop_data (fifo_data),
        .pop      (retire)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_ISSUE;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n      = state_r;
        req_v        = 1'b0;
        trace_yumi   = 1'b0;
        print_stat_v = 1'b0;
        done_consume = 1'b0;
        unique case (state_r)
            ST_ISSUE: begin
                if (bus.trace_v_i) begin
                    if (is_mem) begin
                        req_v      = can_issue;
                        trace_yumi = can_issue & bus.ready_i;
                    end else begin
                        trace_yumi = 1'b1;
                        if (op == TRACE_DONE) begin
                            done_consume = 1'b1;
                            state_n      = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // the strobe fires in the single cycle the machine leaves DRAIN
                if (outstanding_r == '0) begin
                    print_stat_v = 1'b1;
                    state_n      = ST_FIN;
                end
            end
            ST_FIN: begin
                state_n = ST_FIN;
            end
            default: begin
                state_n = ST_ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            outstanding_r <= '0;
        end else begin
            case ({issue, retire})
                2'b10:   outstanding_r <= outstanding_r + out_w'(1);
                2'b01:   outstanding_r <= outstanding_r - out_w'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tag_r            <= '0;
            error_r          <= 1'b0;
            ld_count_r       <= '0;
            st_count_r       <= '0;
            mismatch_count_r <= '0;
        end else begin
            if (done_consume) begin
                tag_r <= bus.trace_data_i;
            end
            if (bus.v_i && !fifo_v) begin
                error_r <= 1'b1;
            end
            if (retire) begin
                if (fifo_data[data_width_p]) begin
                    ld_count_r <= ld_count_r + 32'd1;
                    if (fifo_data[data_width_p-1:0] != bus.data_i) begin
                        mismatch_count_r <= mismatch_count_r + 32'd1;
                    end
                end else begin
                    st_count_r <= st_count_r + 32'd1;
                end
            end
        end
    end

    assign ld_count_o       = ld_count_r;
    assign st_count_o       = st_count_r;
    assign mismatch_count_o = mismatch_count_r;
    assign error_o          = error_r;
    assign print_stat_v_o   = print_stat_v;
    assign print_stat_tag_o = print_stat_v ? tag_r : '0;
    assign done_o           = print_stat_v | (state_r == ST_FIN);

endmodule

// File: tb/tb_vcache_req_driver.sv
// tb/tb_vcache_req_driver.sv - self-checking bench for vcache_req_driver with a queue-based reference model
module tb_vcache_req_driver;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 4;
    localparam int PW   = 6 + AW + DW + DW / 8;

    localparam logic [1:0] OP_LD   = 2'd0;
    localparam logic [1:0] OP_ST   = 2'd1;
    localparam logic [1:0] OP_DONE = 2'd2;
    localparam logic [1:0] OP_NOP  = 2'd3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]   ld_count, st_count, mismatch_count;
    logic          print_stat_v, done, error;
    logic [DW-1:0] print_stat_tag;

    vcache_req_driver_if #(.addr_width_p(AW), .data_width_p(DW)) bus ();

    vcache_req_driver #(
        .addr_width_p(AW),
        .data_width_p(DW),
        .max_out_p   (MAXO)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .bus             (bus),
        .ld_count_o      (ld_count),
        .st_count_o      (st_count),
        .mismatch_count_o(mismatch_count),
        .print_stat_v_o  (print_stat_v),
        .print_stat_tag_o(print_stat_tag),
        .done_o          (done),
        .error_o         (error)
    );

    int checks = 0;
    int failures = 0;

    // reference model: in-flight requests in issue order plus spec-level counters
    bit            m_is_ld[$];
    logic [DW-1:0] m_exp[$];
    logic [31:0]   m_ld, m_st, m_mm;
    bit            m_err;
    int            m_phase;        // 0 issuing, 1 draining, 2 finished
    logic [DW-1:0] m_tag;
    bit            m_consumed;
    int            strobes;
    int            issued;

    function automatic logic [DW-1:0] front_data();
        return (m_exp.size() > 0) ? m_exp[0] : '0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset            = 1'b1;
        bus.trace_v_i    = 1'b0;
        bus.trace_op_i   = OP_NOP;
        bus.trace_addr_i = '0;
        bus.trace_data_i = '0;
        bus.ready_i      = 1'b0;
        bus.v_i          = 1'b0;
        bus.data_i       = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_is_ld.delete();
        m_exp.delete();
        m_ld = '0; m_st = '0; m_mm = '0;
        m_err = 1'b0; m_phase = 0; m_tag = '0;
        strobes = 0; issued = 0;
    endtask

    task automatic cycle(input bit tv, input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input bit rdy, input bit rv,
                         input logic [DW-1:0] rdata);
        bit            mem_op, can, ev, ey, es, ed, ld_e;
        logic [DW-1:0] e;
        logic [PW-1:0] epkt;
        @(negedge clk);
        bus.trace_v_i    = tv;
        bus.trace_op_i   = op;
        bus.trace_addr_i = addr;
        bus.trace_data_i = data;
        bus.ready_i      = rdy;
        bus.v_i          = rv;
        bus.data_i       = rdata;
        #1;
        mem_op = (op == OP_LD) || (op == OP_ST);
        can    = m_exp.size() < MAXO;
        ev     = (m_phase == 0) && tv && mem_op && can;
        ey     = (m_phase == 0) && tv && (mem_op ? (ev && rdy) : 1'b1);
        es     = (m_phase == 1) && (m_exp.size() == 0);
        ed     = (m_phase == 2) || es;
        checks++;
        if (bus.v_o !== ev) begin
            failures++; $display("FAIL v_o got %b want %b at %0t", bus.v_o, ev, $time);
        end
        checks++;
        if (bus.trace_yumi_o !== ey) begin
            failures++; $display("FAIL trace_yumi got %b want %b at %0t", bus.trace_yumi_o, ey, $time);
        end
        checks++;
        if (bus.yumi_o !== rv) begin
            failures++; $display("FAIL yumi_o got %b want %b at %0t", bus.yumi_o, rv, $time);
        end
        checks++;
        if (print_stat_v !== es) begin
            failures++; $display("FAIL print_stat_v got %b want %b at %0t", print_stat_v, es, $time);
        end
        checks++;
        if (done !== ed) begin
            failures++; $display("FAIL done got %b want %b at %0t", done, ed, $time);
        end
        checks++;
        if (error !== m_err) begin
            failures++; $display("FAIL error got %b want %b at %0t", error, m_err, $time);
        end
        checks++;
        if ({ld_count, st_count, mismatch_count} !== {m_ld, m_st, m_mm}) begin
            failures++;
            $display("FAIL counters got ld=%0d st=%0d mm=%0d want ld=%0d st=%0d mm=%0d at %0t",
                     ld_count, st_count, mismatch_count, m_ld, m_st, m_mm, $time);
        end
        if (ev) begin
            // bsg_cache encodings: SW = 001010, LW = 000010; full byte mask
            epkt = {(op == OP_ST) ? 6'b001010 : 6'b000010, addr, data, 4'hF};
            checks++;
            if (bus.cache_pkt_o !== epkt) begin
                failures++; $display("FAIL cache_pkt got %h want %h at %0t", bus.cache_pkt_o, epkt, $time);
            end
        end
        if (es) begin
            checks++;
            if (print_stat_tag !== m_tag) begin
                failures++; $display("FAIL stat_tag got %h want %h at %0t", print_stat_tag, m_tag, $time);
            end
        end
        if (print_stat_v === 1'b1) strobes++;

        if (rv) begin
            if (m_exp.size() == 0) begin
                m_err = 1'b1;
            end else begin
                ld_e = m_is_ld.pop_front();
                e    = m_exp.pop_front();
                if (ld_e) begin
                    m_ld++;
                    if (rdata !== e) m_mm++;
                end else begin
                    m_st++;
                end
            end
        end
        if (ev && rdy) begin
            m_is_ld.push_back(op == OP_LD);
            m_exp.push_back(data);
            issued++;
        end
        if (m_phase == 0 && tv && op == OP_DONE) begin
            m_tag   = data;
            m_phase = 1;
        end
        if (es) m_phase = 2;
        m_consumed = ey;
    endtask

    task automatic idle();
        cycle(1'b0, OP_NOP, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic drain_responses(input int budget);
        int guard = 0;
        while (m_exp.size() > 0 && guard < budget) begin
            cycle(1'b0, OP_NOP, '0, '0, 1'b0, 1'b1, front_data());
            guard++;
        end
        checks++;
        if (m_exp.size() != 0) begin
            failures++; $display("FAIL drain_timeout got %0d left want 0", m_exp.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        idle();
        idle();
        checks++;
        if ({ld_count, st_count, mismatch_count, done, error, print_stat_v} !== '0) begin
            failures++; $display("FAIL reset_outputs got %h want 0",
                                 {ld_count, st_count, mismatch_count, done, error, print_stat_v});
        end
    endtask

    task automatic test_basic();
        do_reset();
        cycle(1'b1, OP_ST, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, '0);
        cycle(1'b1, OP_LD, 32'h100, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0);
        cycle(1'b1, OP_DONE, '0, 32'd7, 1'b1, 1'b1, 32'hDEADBEEF);
        repeat (5) idle();
        checks++;
        if ({st_count, ld_count, mismatch_count} !== {32'd1, 32'd1, 32'd0}) begin
            failures++; $display("FAIL basic_counts got st=%0d ld=%0d mm=%0d want 1 1 0",
                                 st_count, ld_count, mismatch_count);
        end
        checks++;
        if (strobes != 1 || done !== 1'b1) begin
            failures++; $display("FAIL basic_strobe got strobes=%0d done=%b want 1 1", strobes, done);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        cycle(1'b1, OP_LD, 32'h40, 32'h5, 1'b1, 1'b0, '0);
        cycle(1'b0, OP_NOP, '0, '0, 1'b0, 1'b1, 32'h6);
        idle();
        checks++;
        if ({mismatch_count, ld_count, 31'd0, error} !== {32'd1, 32'd1, 32'd0}) begin
            failures++; $display("FAIL mismatch got mm=%0d ld=%0d err=%b want 1 1 0",
                                 mismatch_count, ld_count, error);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (10) cycle(1'b1, OP_LD, 32'h200, 32'h1234, 1'b0, 1'b0, '0);
        checks++;
        if (issued != 0) begin
            failures++; $display("FAIL bp_hold got issued=%0d want 0", issued);
        end
        cycle(1'b1, OP_LD, 32'h200, 32'h1234, 1'b1, 1'b0, '0);
        cycle(1'b0, OP_NOP, '0, '0, 1'b0, 1'b1, 32'h1234);
        idle();
        checks++;
        if (issued != 1 || ld_count !== 32'd1) begin
            failures++; $display("FAIL bp_release got issued=%0d ld=%0d want 1 1", issued, ld_count);
        end
    endtask

    task automatic test_max_out();
        int pending = 6;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(pending > 0, OP_LD, 32'h1000 + 32'(4 * pending), 32'(pending), 1'b1, 1'b0, '0);
            if (m_consumed) pending--;
        end
        checks++;
        if (issued != MAXO || pending != 2) begin
            failures++; $display("FAIL max_out got issued=%0d pending=%0d want %0d 2", issued, pending, MAXO);
        end
        for (int i = 0; i < 30 && (pending > 0 || m_exp.size() > 0); i++) begin
            cycle(pending > 0, OP_LD, 32'h1000 + 32'(4 * pending), 32'(pending), 1'b1, 1'b1, front_data());
            if (m_consumed) pending--;
        end
        idle();
        checks++;
        if (ld_count !== 32'd6 || mismatch_count !== 32'd0) begin
            failures++; $display("FAIL max_out_final got ld=%0d mm=%0d want 6 0", ld_count, mismatch_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        int         exp_ld = 0;
        do_reset();
        cycle(1'b1, OP_LD, 32'h80, 32'hA0, 1'b1, 1'b0, '0);
        exp_ld = 1;
        for (int i = 0; i < 20; i++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_LD : OP_ST;
            cycle(1'b1, op, 32'($urandom), 32'($urandom), 1'b1, 1'b1, front_data());
            if (i < 19 && op == OP_LD) exp_ld++;
        end
        idle();
        checks++;
        if (issued != 21 || ld_count !== 32'(exp_ld) || st_count !== 32'(20 - exp_ld)) begin
            failures++; $display("FAIL b2b got issued=%0d ld=%0d st=%0d want 21 %0d %0d",
                                 issued, ld_count, st_count, exp_ld, 20 - exp_ld);
        end
        drain_responses(10);
    endtask

    task automatic test_error_done();
        do_reset();
        cycle(1'b0, OP_NOP, '0, '0, 1'b0, 1'b1, 32'h55);
        repeat (3) idle();
        checks++;
        if (error !== 1'b1 || {ld_count, st_count, mismatch_count} !== '0) begin
            failures++; $display("FAIL error_sticky got err=%b ld=%0d st=%0d want 1 0 0", error, ld_count, st_count);
        end
        cycle(1'b1, OP_DONE, '0, 32'hA5, 1'b1, 1'b0, '0);
        repeat (8) cycle(1'b1, OP_LD, 32'h4, 32'h9, 1'b1, 1'b0, '0);
        checks++;
        if (strobes != 1 || done !== 1'b1 || error !== 1'b1) begin
            failures++; $display("FAIL done_once got strobes=%0d done=%b err=%b want 1 1 1", strobes, done, error);
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        int         guard;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    op = OP_LD;
                2, 3:    op = OP_ST;
                default: op = OP_NOP;
            endcase
            cycle($urandom_range(0, 3) != 0, op, 32'($urandom), 32'($urandom), $urandom_range(0, 2) != 0,
                  (m_exp.size() > 0) && ($urandom_range(0, 2) != 0),
                  front_data() ^ (($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0));
        end
        guard = 0;
        while (m_phase == 0 && guard < 20) begin
            cycle(1'b1, OP_DONE, '0, 32'h3C, 1'b1, m_exp.size() > 0, front_data());
            guard++;
        end
        guard = 0;
        while (m_phase != 2 && guard < 50) begin
            cycle(1'b0, OP_NOP, '0, '0, 1'b0, (m_exp.size() > 0) && ($urandom_range(0, 1) == 1), front_data());
            guard++;
        end
        repeat (3) idle();
        checks++;
        if (done !== 1'b1 || strobes != 1 || error !== 1'b0) begin
            failures++; $display("FAIL random_end got done=%b strobes=%0d err=%b want 1 1 0", done, strobes, error);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_backpressure();
        test_max_out();
        test_back_to_back();
        test_error_done();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
